cut_pulse_checker: RTL and testbench

- Receive-side checker for the cutter's cut-pulse stream; sits downstream of the cut-pulse generator, or on the blade-sensor input.
- Measures the CLK-cycle distance between successive cut pulses and compares each distance with the programmed segment length sequence (len1, len2, len3, repeating).
- Reports each measurement, flags mismatches and timeouts, and keeps a saturating error count for the operator panel.

---
 rtl/cutter_pkg.sv | 21 ++
 rtl/cut_edge_sync.sv | 27 ++
 rtl/cut_pulse_checker.sv | 133 +++++++++++++
 tb/tb_cut_pulse_checker.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cutter_pkg.sv
// rtl/cutter_pkg.sv - shared FSM encoding and segment-count mapping for the cut-pulse checker
package cutter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int SEG_MAX = 3;

  // nol encodes segments-per-sequence; 2 and 3 both mean the full three-segment sequence
  function automatic logic [1:0] nol_to_nseg(input logic [1:0] nol);
    case (nol)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'(SEG_MAX);
    endcase
  endfunction

endpackage

// File: rtl/cut_edge_sync.sv
// rtl/cut_edge_sync.sv - two-flop synchronizer and rising-edge detector for the cut pulse
module cut_edge_sync (
  input  logic CLK,
  input  logic CLR,
  input  logic i_cut,
  output logic o_edge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_cut;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_edge = r_s2 & ~r_s3;

endmodule

// File: rtl/cut_pulse_checker.sv
// rtl/cut_pulse_checker.sv - measures cut-pulse spacing against the programmed segment lengths
module cut_pulse_checker
  import cutter_pkg::*;
#(
  parameter int CW  = 8,
  parameter int TOL = 0
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          en,
  input  logic          cut_in,
  input  logic [3:0]    len1,
  input  logic [3:0]    len2,
  input  logic [3:0]    len3,
  input  logic [1:0]    nol,
  output logic [CW-1:0] meas_len,
  output logic          meas_valid,
  output logic [1:0]    seg_idx,
  output logic          err_pulse,
  output logic [3:0]    err_cnt,
  output logic          busy
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [CW-1:0] r_meas_len, w_meas_len_n;
  logic [1:0]    r_seg, w_seg_n;
  logic [1:0]    r_nseg, w_nseg_n;
  logic          r_mv, w_mv_n;
  logic          r_ep, w_ep_n;
  logic [3:0]    r_err_cnt;
  logic          w_edge;
  logic [3:0]    w_len;
  logic [CW-1:0] w_exp;
  logic [CW-1:0] w_diff;
  logic          w_match;

  cut_edge_sync u_sync (
    .CLK    (CLK),
    .CLR    (CLR),
    .i_cut  (cut_in),
    .o_edge (w_edge)
  );

  always_comb begin
    case (r_seg)
      2'd0:    w_len = len1;
      2'd1:    w_len = len2;
      default: w_len = len3;
    endcase
  end

  assign w_exp   = CW'(w_len) + CW'(1);
  assign w_diff  = (r_cnt >= w_exp) ? (r_cnt - w_exp) : (w_exp - r_cnt);
  assign w_match = (w_diff <= CW'(TOL));

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_seg_n      = r_seg;
    w_nseg_n     = r_nseg;
    w_meas_len_n = r_meas_len;
    w_mv_n       = 1'b0;
    w_ep_n       = 1'b0;
    // Disable has priority over any edge arriving in the same cycle
    if (!en) begin
      w_state_n = IDLE;
      w_cnt_n   = '0;
      w_seg_n   = 2'd0;
    end else begin
      case (r_state)
        IDLE: w_state_n = ARMED;
        ARMED: begin
          if (w_edge) begin
            w_state_n = MEASURE;
            w_cnt_n   = CW'(1);
            w_seg_n   = 2'd0;
            w_nseg_n  = nol_to_nseg(nol);
          end
        end
        MEASURE: begin
          if (w_edge) begin
            w_meas_len_n = r_cnt;
            w_mv_n       = 1'b1;
            w_ep_n       = ~w_match;
            w_cnt_n      = CW'(1);
            w_seg_n      = (r_seg == r_nseg - 2'd1) ? 2'd0 : r_seg + 2'd1;
          end else if (r_cnt == CNT_MAX) begin
            w_ep_n    = 1'b1;
            w_state_n = ARMED;
            w_cnt_n   = '0;
            w_seg_n   = 2'd0;
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_seg      <= 2'd0;
      r_nseg     <= 2'd1;
      r_meas_len <= '0;
      r_mv       <= 1'b0;
      r_ep       <= 1'b0;
      r_err_cnt  <= 4'd0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_seg      <= w_seg_n;
      r_nseg     <= w_nseg_n;
      r_meas_len <= w_meas_len_n;
      r_mv       <= w_mv_n;
      r_ep       <= w_ep_n;
      if (w_ep_n && (r_err_cnt != 4'hF)) r_err_cnt <= r_err_cnt + 4'd1;
    end
  end

  assign meas_len   = r_meas_len;
  assign meas_valid = r_mv;
  assign seg_idx    = r_seg;
  assign err_pulse  = r_ep;
  assign err_cnt    = r_err_cnt;
  assign busy       = (r_state == MEASURE);

endmodule

// File: tb/tb_cut_pulse_checker.sv
// tb/tb_cut_pulse_checker.sv - directed table-driven bench for cut_pulse_checker
module tb_cut_pulse_checker;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       en = 1'b0;
  logic       cut_in = 1'b0;
  logic [3:0] len1 = 4'd0, len2 = 4'd0, len3 = 4'd0;
  logic [1:0] nol = 2'd0;

  logic [7:0] meas_len, meas_len2;
  logic       meas_valid, meas_valid2;
  logic [1:0] seg_idx, seg_idx2;
  logic       err_pulse, err_pulse2;
  logic [3:0] err_cnt, err_cnt2;
  logic       busy, busy2;

  cut_pulse_checker #(.CW(8), .TOL(0)) u_dut (
    .CLK(CLK), .CLR(CLR), .en(en), .cut_in(cut_in),
    .len1(len1), .len2(len2), .len3(len3), .nol(nol),
    .meas_len(meas_len), .meas_valid(meas_valid), .seg_idx(seg_idx),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .busy(busy)
  );

  cut_pulse_checker #(.CW(8), .TOL(2)) u_dut_t2 (
    .CLK(CLK), .CLR(CLR), .en(en), .cut_in(cut_in),
    .len1(len1), .len2(len2), .len3(len3), .nol(nol),
    .meas_len(meas_len2), .meas_valid(meas_valid2), .seg_idx(seg_idx2),
    .err_pulse(err_pulse2), .err_cnt(err_cnt2), .busy(busy2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int cyc;
    int len;
    int seg;
    int err;
  } ev_t;

  typedef struct {
    int grp;
    int sp;
    int elen;
    int eseg;
    int eerr;
  } vec_t;

  ev_t  mq[$];
  int   cyc = 0;
  int   err_ev_cnt = 0;
  int   err_ev_last = -1;
  int   checks = 0;
  int   fails = 0;
  vec_t tbl[8];

  // Measurement/error monitor, sampled mid-cycle
  always @(negedge CLK) begin
    if (meas_valid) begin
      ev_t e;
      e.cyc = cyc;
      e.len = int'(meas_len);
      e.seg = int'(seg_idx);
      e.err = int'(err_pulse);
      mq.push_back(e);
    end
    if (err_pulse) begin
      err_ev_cnt  <= err_ev_cnt + 1;
      err_ev_last <= cyc;
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse(output int ic);
    ic = cyc;
    cut_in = 1'b1;
    step(1);
    cut_in = 1'b0;
  endtask

  task automatic do_reset();
    en = 1'b0;
    cut_in = 1'b0;
    CLR = 1'b0;
    step(2);
    CLR = 1'b1;
  endtask

  task automatic run_group(input int g);
    int ic[$];
    int tmp;
    int b;
    int eb;
    int k;
    do_reset();
    nol = 2'd2; len1 = 4'd1; len2 = 4'd2; len3 = 4'd3;
    en = 1'b1;
    step(1);
    b  = mq.size();
    eb = err_ev_cnt;
    pulse(tmp);
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].grp == g) begin
        step(tbl[i].sp - 1);
        pulse(tmp);
        ic.push_back(tmp);
      end
    end
    step(8);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].grp == g) begin
        if (b + k < mq.size()) begin
          chk($sformatf("g%0d_m%0d_lat", g, k), mq[b+k].cyc, ic[k] + 3);
          chk($sformatf("g%0d_m%0d_len", g, k), mq[b+k].len, tbl[i].elen);
          chk($sformatf("g%0d_m%0d_seg", g, k), mq[b+k].seg, tbl[i].eseg);
          chk($sformatf("g%0d_m%0d_err", g, k), mq[b+k].err, tbl[i].eerr);
        end else begin
          chk($sformatf("g%0d_m%0d_missing", g, k), 0, 1);
        end
        k++;
      end
    end
    chk($sformatf("g%0d_meas_count", g), mq.size() - b, k);
    chk($sformatf("g%0d_err_events", g), err_ev_cnt - eb, (g == 1) ? 1 : 0);
    chk($sformatf("g%0d_err_cnt", g), int'(err_cnt), (g == 1) ? 1 : 0);
    chk($sformatf("g%0d_err_cnt_tol2", g), int'(err_cnt2), 0);
  endtask

  initial begin
    int ic;
    int b;
    int eb;
    int bad;

    tbl[0] = '{0, 2, 2, 1, 0};
    tbl[1] = '{0, 3, 3, 2, 0};
    tbl[2] = '{0, 4, 4, 0, 0};
    tbl[3] = '{0, 2, 2, 1, 0};
    tbl[4] = '{1, 2, 2, 1, 0};
    tbl[5] = '{1, 5, 5, 2, 1};
    tbl[6] = '{1, 4, 4, 0, 0};
    tbl[7] = '{1, 2, 2, 1, 0};

    // Reset state
    step(2);
    chk("rst_meas_len", int'(meas_len), 0);
    chk("rst_meas_valid", int'(meas_valid), 0);
    chk("rst_seg_idx", int'(seg_idx), 0);
    chk("rst_err_pulse", int'(err_pulse), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_busy", int'(busy), 0);

    // Timeout: arm once, then no further pulses
    do_reset();
    nol = 2'd2; len1 = 4'd1; len2 = 4'd2; len3 = 4'd3;
    en = 1'b1;
    step(1);
    b  = mq.size();
    eb = err_ev_cnt;
    pulse(ic);
    step(299);
    chk("to_err_events", err_ev_cnt - eb, 1);
    chk("to_err_cycle", err_ev_last, ic + 258);
    chk("to_err_cnt", int'(err_cnt), 1);
    chk("to_err_cnt_tol2", int'(err_cnt2), 1);
    chk("to_no_meas", mq.size() - b, 0);
    chk("to_busy", int'(busy), 0);
    chk("to_state_armed", int'(u_dut.r_state), 1);
    chk("to_seg_idx", int'(seg_idx), 0);

    run_group(0);
    run_group(1);

    // nol=0: single-segment sequence, then a held pulse
    do_reset();
    nol = 2'd0; len1 = 4'd4; len2 = 4'd9; len3 = 4'd9;
    en = 1'b1;
    step(1);
    b  = mq.size();
    eb = err_ev_cnt;
    pulse(ic);
    repeat (20) begin
      step(4);
      pulse(ic);
    end
    step(4);
    ic = cyc;
    cut_in = 1'b1;
    step(3);
    cut_in = 1'b0;
    step(8);
    chk("nol0_meas_count", mq.size() - b, 21);
    bad = 0;
    for (int i = b; i < mq.size(); i++)
      if (mq[i].len != 5 || mq[i].seg != 0 || mq[i].err != 0) bad++;
    chk("nol0_bad_entries", bad, 0);
    if (mq.size() > 0) chk("held_pulse_lat", mq[mq.size()-1].cyc, ic + 3);
    chk("nol0_err_events", err_ev_cnt - eb, 0);

    // Error counter saturation, then disable
    do_reset();
    nol = 2'd1; len1 = 4'd4; len2 = 4'd4;
    en = 1'b1;
    step(1);
    eb = err_ev_cnt;
    pulse(ic);
    repeat (17) begin
      step(2);
      pulse(ic);
    end
    step(6);
    chk("sat_err_events", err_ev_cnt - eb, 17);
    chk("sat_err_cnt", int'(err_cnt), 15);
    chk("sat_err_cnt_tol2", int'(err_cnt2), 0);
    chk("sat_seg_idx", int'(seg_idx), 1);
    chk("sat_meas_len", int'(meas_len), 3);
    en = 1'b0;
    step(2);
    chk("dis_busy", int'(busy), 0);
    chk("dis_seg_idx", int'(seg_idx), 0);
    chk("dis_err_cnt", int'(err_cnt), 15);
    chk("dis_meas_len", int'(meas_len), 3);
    chk("dis_state_idle", int'(u_dut.r_state), 0);

    // Asynchronous reset in the middle of a measurement
    en = 1'b1;
    step(1);
    pulse(ic);
    step(8);
    chk("mid_busy", int'(busy), 1);
    chk("mid_cnt", int'(u_dut.r_cnt), 7);
    #2;
    CLR = 1'b0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_err_cnt", int'(err_cnt), 0);
    chk("async_meas_len", int'(meas_len), 0);
    chk("async_seg_idx", int'(seg_idx), 0);
    chk("async_meas_valid", int'(meas_valid), 0);
    chk("async_err_pulse", int'(err_pulse), 0);
    step(1);
    CLR = 1'b1;
    step(1);
    b = mq.size();
    pulse(ic);
    step(10);
    chk("rearm_no_meas", mq.size() - b, 0);
    chk("rearm_busy", int'(busy), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
